// File: rtl/game_countdown_timer.sv
// game_countdown_timer
//   Level countdown timer for the Gold Miner game. Decrements the remaining
//   level time on each one-second strobe. Supports pause, bonus time, reload
//   at level start and freeze at level end. Every output is registered.
//
// Ports
//   clk, resetN          system clock, asynchronous active-low reset
//   sec_pulse            one-cycle strobe per second from the pulse generator
//   start                load START_SECONDS and run (highest priority)
//   stop                 freeze the count and go idle (RUNNING/PAUSED only)
//   pause                level-sensitive hold
//   add_en, add_val      one-cycle bonus-time request; add_val is clamped to 99
//   seconds_left         remaining seconds, binary
//   tens_digit/ones_digit BCD digits of seconds_left
//   running              high in RUNNING
//   warning, blink       low-time warning and its blink phase
//   time_up              sticky, high in EXPIRED
//   time_up_pulse        one-cycle strobe on expiry
module game_countdown_timer #(
  parameter int unsigned START_SECONDS = 60,
  parameter int unsigned MAX_SECONDS   = 99,
  parameter int unsigned WARN_SECONDS  = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       sec_pulse,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       add_en,
  input  logic [6:0] add_val,
  output logic [6:0] seconds_left,
  output logic [3:0] tens_digit,
  output logic [3:0] ones_digit,
  output logic       running,
  output logic       warning,
  output logic       blink,
  output logic       time_up,
  output logic       time_up_pulse
);

  localparam int unsigned SECS_W  = 7;
  localparam int unsigned SUM_W   = 8;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [SECS_W-1:0]  START_V    = SECS_W'(START_SECONDS);
  localparam logic [SECS_W-1:0]  WARN_V     = SECS_W'(WARN_SECONDS);
  localparam logic [SUM_W-1:0]   MAX_SUM_V  = SUM_W'(MAX_SECONDS);
  localparam logic [SUM_W-1:0]   ADD_CAP_V  = SUM_W'(99);
  localparam logic [DIGIT_W-1:0] START_TENS = DIGIT_W'(START_SECONDS / 10);
  localparam logic [DIGIT_W-1:0] START_ONES = DIGIT_W'(START_SECONDS % 10);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t              r_state;
  logic [SECS_W-1:0]   r_secs;
  logic [DIGIT_W-1:0]  r_tens;
  logic [DIGIT_W-1:0]  r_ones;
  logic                r_running;
  logic                r_warning;
  logic                r_blink;
  logic                r_time_up;
  logic                r_time_up_pulse;

  state_t              w_state_nxt;
  logic [SECS_W-1:0]   w_secs_nxt;
  logic                w_blink_nxt;
  logic                w_pulse_nxt;
  logic                w_warn_nxt;
  logic [DIGIT_W-1:0]  w_tens_nxt;
  logic [DIGIT_W-1:0]  w_ones_nxt;

  logic [SUM_W-1:0]    w_add;
  logic                w_dec;
  logic [SUM_W-1:0]    w_sum;
  logic [SECS_W-1:0]   w_upd;

  // Bonus seconds, clamped to two BCD digits before use.
  always_comb begin
    w_add = '0;
    if (add_en) begin
      w_add = (SUM_W'(add_val) > ADD_CAP_V) ? ADD_CAP_V : SUM_W'(add_val);
    end
  end

  // A decrement applies only while running and not being paused this cycle.
  assign w_dec = (r_state == ST_RUNNING) && !pause && sec_pulse;

  // Combined add/decrement in 8 bits, then saturated at MAX_SECONDS.
  // RUNNING always holds a count of at least 1, so the subtraction cannot wrap.
  assign w_sum = SUM_W'(r_secs) + w_add - SUM_W'(w_dec);
  assign w_upd = (w_sum > MAX_SUM_V) ? SECS_W'(MAX_SECONDS) : SECS_W'(w_sum);

  // Next state, next count, blink phase and expiry strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_secs_nxt  = r_secs;
    w_blink_nxt = r_blink;
    w_pulse_nxt = 1'b0;

    if (start) begin
      w_state_nxt = ST_RUNNING;
      w_secs_nxt  = START_V;
      w_blink_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_RUNNING: begin
          if (stop) begin
            w_state_nxt = ST_IDLE;
          end else if (pause) begin
            w_state_nxt = ST_PAUSED;
          end else begin
            w_secs_nxt = w_upd;
            if (w_dec && (w_upd >= SECS_W'(1)) && (w_upd <= WARN_V)) begin
              w_blink_nxt = ~r_blink;
            end
            if (w_upd == '0) begin
              w_state_nxt = ST_EXPIRED;
              w_pulse_nxt = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            // Bonus time is still honoured while paused; no decrement here.
            w_secs_nxt = w_upd;
            if (!pause) begin
              w_state_nxt = ST_RUNNING;
            end
          end
        end
        default: begin
          // IDLE and EXPIRED ignore everything except start.
        end
      endcase
    end

    w_warn_nxt = ((w_state_nxt == ST_RUNNING) || (w_state_nxt == ST_PAUSED)) &&
                 (w_secs_nxt >= SECS_W'(1)) && (w_secs_nxt <= WARN_V);
    if (!w_warn_nxt) begin
      w_blink_nxt = 1'b0;
    end
  end

  // BCD digits derived from the same next value as the binary count.
  assign w_tens_nxt = DIGIT_W'(w_secs_nxt / SECS_W'(10));
  assign w_ones_nxt = DIGIT_W'(w_secs_nxt % SECS_W'(10));

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state         <= ST_IDLE;
      r_secs          <= START_V;
      r_tens          <= START_TENS;
      r_ones          <= START_ONES;
      r_running       <= 1'b0;
      r_warning       <= 1'b0;
      r_blink         <= 1'b0;
      r_time_up       <= 1'b0;
      r_time_up_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_secs          <= w_secs_nxt;
      r_tens          <= w_tens_nxt;
      r_ones          <= w_ones_nxt;
      r_running       <= (w_state_nxt == ST_RUNNING);
      r_warning       <= w_warn_nxt;
      r_blink         <= w_blink_nxt;
      r_time_up       <= (w_state_nxt == ST_EXPIRED);
      r_time_up_pulse <= w_pulse_nxt;
    end
  end

  assign seconds_left  = r_secs;
  assign tens_digit    = r_tens;
  assign ones_digit    = r_ones;
  assign running       = r_running;
  assign warning       = r_warning;
  assign blink         = r_blink;
  assign time_up       = r_time_up;
  assign time_up_pulse = r_time_up_pulse;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Testbench for game_countdown_timer: directed scenarios followed by random
// traffic, all checked against a behavioural model of the timer's rules.
module tb_game_countdown_timer;

  localparam int START = 60;
  localparam int MAXS  = 99;
  localparam int WARN  = 10;

  logic       clk;
  logic       resetN;
  logic       sec_pulse;
  logic       start;
  logic       pause;
  logic       stop;
  logic       add_en;
  logic [6:0] add_val;
  logic [6:0] seconds_left;
  logic [3:0] tens_digit;
  logic [3:0] ones_digit;
  logic       running;
  logic       warning;
  logic       blink;
  logic       time_up;
  logic       time_up_pulse;

  game_countdown_timer #(
    .START_SECONDS(START),
    .MAX_SECONDS  (MAXS),
    .WARN_SECONDS (WARN)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .sec_pulse    (sec_pulse),
    .start        (start),
    .pause        (pause),
    .stop         (stop),
    .add_en       (add_en),
    .add_val      (add_val),
    .seconds_left (seconds_left),
    .tens_digit   (tens_digit),
    .ones_digit   (ones_digit),
    .running      (running),
    .warning      (warning),
    .blink        (blink),
    .time_up      (time_up),
    .time_up_pulse(time_up_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a level is "live" while counting or paused.
  int m_secs;
  bit m_live;
  bit m_paused;
  bit m_expired;
  bit m_blink;
  bit m_pulse;

  function automatic bit m_warn();
    return m_live && (m_secs >= 1) && (m_secs <= WARN);
  endfunction

  function automatic void model_reset();
    m_secs    = START;
    m_live    = 1'b0;
    m_paused  = 1'b0;
    m_expired = 1'b0;
    m_blink   = 1'b0;
    m_pulse   = 1'b0;
  endfunction

  function automatic void model_step(input bit st, input bit sp, input bit pa,
                                     input bit ae, input int av, input bit pl);
    int add;
    int dec;
    int n;
    m_pulse = 1'b0;
    if (st) begin
      m_secs = START; m_live = 1'b1; m_paused = 1'b0; m_expired = 1'b0; m_blink = 1'b0;
    end else if (m_live && sp) begin
      m_live = 1'b0; m_paused = 1'b0;
    end else if (m_live && !m_paused && pa) begin
      m_paused = 1'b1;
    end else if (m_live) begin
      add = ae ? ((av > 99) ? 99 : av) : 0;
      dec = (!m_paused && pl) ? 1 : 0;
      n = m_secs + add - dec;
      if (n > MAXS) n = MAXS;
      if (dec == 1 && n >= 1 && n <= WARN) m_blink = !m_blink;
      m_secs = n;
      if (m_paused && !pa) m_paused = 1'b0;
      if (n == 0) begin
        m_live = 1'b0; m_expired = 1'b1; m_pulse = 1'b1;
      end
    end
    if (!m_warn()) m_blink = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".secs"},  8'(seconds_left),  8'(m_secs));
    chk({tag, ".tens"},  8'(tens_digit),    8'(m_secs / 10));
    chk({tag, ".ones"},  8'(ones_digit),    8'(m_secs % 10));
    chk({tag, ".run"},   8'(running),       8'(m_live && !m_paused));
    chk({tag, ".warn"},  8'(warning),       8'(m_warn()));
    chk({tag, ".blink"}, 8'(blink),         8'(m_blink));
    chk({tag, ".tup"},   8'(time_up),       8'(m_expired));
    chk({tag, ".tupp"},  8'(time_up_pulse), 8'(m_pulse));
  endtask

  task automatic go(input bit st, input bit sp, input bit pa, input bit ae,
                    input int av, input bit pl, input string tag);
    start = st; stop = sp; pause = pa; add_en = ae; add_val = 7'(av); sec_pulse = pl;
    @(posedge clk);
    model_step(st, sp, pa, ae, av, pl);
    #1;
    check_all(tag);
  endtask

  // Apply plain pulses until the model reaches the target count (bounded).
  task automatic run_to(input int target, input string tag);
    int guard;
    guard = 0;
    while (m_secs != target && guard < 200) begin
      go(0, 0, 0, 0, 0, 1, tag);
      guard++;
    end
    chk({tag, ".reached"}, 8'(m_secs == target), 8'd1);
  endtask

  bit r_pause;
  bit r_st;

  initial begin
    resetN = 1'b0; start = 0; stop = 0; pause = 0; add_en = 0; add_val = '0; sec_pulse = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.secs_const", 8'(seconds_left), 8'd60);
    @(negedge clk) resetN = 1'b1;

    // Start and three seconds.
    go(1, 0, 0, 0, 0, 0, "start");
    repeat (3) go(0, 0, 0, 0, 0, 1, "pulse3");
    chk("tp1.secs", 8'(seconds_left), 8'd57);
    chk("tp1.tens", 8'(tens_digit), 8'd5);
    chk("tp1.ones", 8'(ones_digit), 8'd7);

    // Countdown through the warning range to expiry.
    run_to(11, "to11");
    chk("at11.warn", 8'(warning), 8'd0);
    go(0, 0, 0, 0, 0, 1, "to10");
    chk("at10.warn", 8'(warning), 8'd1);
    chk("at10.blink", 8'(blink), 8'd1);
    for (int i = 0; i < 10; i++) go(0, 0, 0, 0, 0, 1, "countdown");
    chk("exp.tup", 8'(time_up), 8'd1);
    chk("exp.tupp", 8'(time_up_pulse), 8'd1);
    chk("exp.run", 8'(running), 8'd0);
    go(0, 0, 0, 0, 0, 0, "exp_hold");
    chk("exp.tupp_once", 8'(time_up_pulse), 8'd0);
    repeat (3) go(0, 0, 1, 1, 20, 1, "exp_ignore");
    chk("exp.secs0", 8'(seconds_left), 8'd0);

    // Bonus time saturation, then add combined with a decrement.
    go(1, 0, 0, 0, 0, 0, "restart");
    go(0, 0, 0, 1, 35, 0, "add35");
    go(0, 0, 0, 1, 20, 0, "add20");
    chk("sat.secs", 8'(seconds_left), 8'd99);
    chk("sat.tens", 8'(tens_digit), 8'd9);
    chk("sat.ones", 8'(ones_digit), 8'd9);
    run_to(5, "to5");
    go(0, 0, 0, 1, 10, 1, "add10dec");
    chk("add10.secs", 8'(seconds_left), 8'd14);
    chk("add10.warn", 8'(warning), 8'd0);
    run_to(1, "to1");
    go(0, 0, 0, 1, 3, 1, "save");
    chk("save.secs", 8'(seconds_left), 8'd3);
    chk("save.tupp", 8'(time_up_pulse), 8'd0);

    // Pause behaviour.
    go(1, 0, 0, 0, 0, 0, "restart2");
    run_to(30, "to30");
    go(0, 0, 1, 0, 0, 1, "pause");
    repeat (5) go(0, 0, 1, 0, 0, 1, "paused");
    chk("paused.secs", 8'(seconds_left), 8'd30);
    go(0, 0, 1, 1, 4, 0, "paused_add");
    go(0, 0, 0, 0, 0, 0, "resume");
    go(0, 0, 0, 0, 0, 1, "resume_dec");
    chk("resume.secs", 8'(seconds_left), 8'd33);

    // Stop, idle ignore, start priority over pulse/add.
    run_to(20, "to20");
    go(0, 1, 0, 0, 0, 0, "stop");
    repeat (3) go(0, 0, 0, 1, 9, 1, "idle_ignore");
    chk("idle.secs", 8'(seconds_left), 8'd20);
    go(1, 0, 0, 1, 50, 1, "start_prio");
    chk("start_prio.secs", 8'(seconds_left), 8'd60);
    run_to(0, "to0");
    go(1, 0, 0, 0, 0, 0, "exp_restart");
    chk("exp_restart.tup", 8'(time_up), 8'd0);

    // Asynchronous reset mid-countdown.
    run_to(12, "to12");
    #2 resetN = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    chk("async_reset.secs", 8'(seconds_left), 8'd60);
    @(negedge clk) resetN = 1'b1;
    go(0, 0, 0, 0, 0, 1, "post_reset");

    // Random traffic against the model.
    r_pause = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 14) == 0) r_pause = !r_pause;
      r_st = m_live ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 19) == 0);
      go(r_st, $urandom_range(0, 149) == 0, r_pause, $urandom_range(0, 19) == 0,
         int'($urandom_range(0, 127)), $urandom_range(0, 2) == 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
